// File: rtl/spi_mem_master.sv
// SPI mode-0 initiator for the shift-register memory slave.
// Sends one 16-bit frame {addr, rw, data} MSB first and captures miso for reads.
module spi_mem_master #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int CW = $clog2(HALF_PERIOD + 1);
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   halfCnt;
  logic [4:0]      bitCnt;
  logic [15:0]     frame;
  logic [15:0]     capture;
  logic            rwReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      halfCnt <= '0;
      bitCnt  <= 5'd0;
      frame   <= 16'h0000;
      capture <= 16'h0000;
      rwReg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new request too, giving a one-cycle cs gap
        IDLE, DONE: begin
          cs    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            state   <= SHIFT;
            cs      <= 1'b0;
            busy    <= 1'b1;
            frame   <= {addr, rw, rw ? 8'h00 : wdata};
            mosi    <= addr[6];
            rwReg   <= rw;
            halfCnt <= '0;
            bitCnt  <= 5'd0;
          end
        end
        SHIFT: begin
          if (halfCnt == HP_LAST) begin
            halfCnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              capture <= {capture[14:0], miso};
              bitCnt  <= bitCnt + 5'd1;
            end else if (bitCnt == 5'd16) begin
              mosi  <= 1'b0;
              state <= TAIL;
            end else begin
              mosi  <= frame[14];
              frame <= {frame[14:0], 1'b0};
            end
          end else begin
            halfCnt <= halfCnt + 1'b1;
          end
        end
        // cs hold time with sclk parked low
        TAIL: begin
          if (halfCnt == HP_LAST) begin
            state <= DONE;
            cs    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rwReg) rdata <= capture[7:0];
          end else begin
            halfCnt <= halfCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- SPI initiator that issues single read/write transactions to the SPI memory slave (the shift-register-based responder), which samples on SCLK rising edges.
- Serialises a 16-bit frame MSB first: {addr[6:0], rw, data[7:0]}.
- Generates SCLK and CS from the system clock.
- On reads, it captures the slave's MISO data.
- Sits between the host/test logic and the memory pins.

Parameters:
HALF_PERIOD, 2, system-clock cycles per SCLK half-period (legal range >= 1); SCLK period = 2*HALF_PERIOD clk cycles

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a transaction; accepted on any posedge where busy==0
rw  input  1  1 = read, 0 = write; captured at accept
addr  input  7  memory address; captured at accept
wdata  input  8  write data; captured at accept (ignored for reads)
busy  output  1  high from the cycle after accept until the done cycle
done  output  1  one-cycle pulse at transaction completion
rdata  output  8  last read data; updated only at done of a read
sclk  output  1  SPI clock, idle low (mode 0)
cs  output  1  chip select, active low, idle high
mosi  output  1  serial data to slave
miso  input  1  serial data from slave

Behaviour:
- Reset (synchronous, highest priority, legal at any time including mid-frame): the next cycle shows sclk=0, cs=1, mosi=0, busy=0, done=0, rdata=8'h00, FSM=IDLE. An aborted frame produces no done pulse.
- Frame register F[15:0] is loaded at accept with {addr, rw, rw ? 8'h00 : wdata}.
- FSM states: IDLE, SHIFT, TAIL, DONE.
- IDLE: start=1 at edge T0 gives state=SHIFT, cs=0, busy=1, mosi=F[15], half-period counter=0. start=0 stays in IDLE.
- SHIFT: the counter counts HALF_PERIOD cycles per phase. Edge times relative to T0:
  - k-th SCLK rise (k=1..16) at T0+(2k-1)*HALF_PERIOD.
  - k-th SCLK fall at T0+2k*HALF_PERIOD.
- On each rise, the master samples miso into a 16-bit capture register, MSB first (same edge the slave samples mosi).
- On falls 1..15, mosi advances to the next frame bit. On fall 16, mosi=0 and the state moves to TAIL.
- TAIL: cs stays low and sclk low for HALF_PERIOD cycles (CS hold time).
- DONE: at T0+33*HALF_PERIOD the cycle shows cs=1, done=1, busy=0.
  - For a read, rdata = miso bits captured on rises 9..16 (rise 9 is rdata[7]).
  - For a write, rdata is unchanged.
- After DONE, return to IDLE next cycle.
- Total latency from accept edge to done = 33*HALF_PERIOD cycles.
- start during the DONE cycle is accepted (busy=0 there). This gives back-to-back frames with cs high for exactly one clk cycle between them.
- start while busy=1 is ignored and not queued. Changes to rw/addr/wdata after accept have no effect.
- sclk toggles only while cs=0. mosi is stable for a full SCLK period around every rise.
- Bit counter is 5 bits (counts 0..16); half-period counter is $clog2(HALF_PERIOD+1) bits. No wrap-around occurs within a frame.

Test Plan:
- Reset: hold reset 2 cycles during an active frame -> the next cycle shows sclk=0, cs=1, mosi=0, busy=0, rdata=00; no done pulse.
- Write: HALF_PERIOD=2, start with rw=0, addr=7'h55, wdata=8'hA3 -> mosi sampled at the 16 rises = 1010101_0_10100011. Exactly 16 rises, done at accept+66 cycles, rdata unchanged.
- Read: rw=1, addr=7'h12; bench slave model drives miso=8'hC6 MSB first on rises 9..16 -> mosi bits = 0010010_1_00000000, rdata=8'hC6 at done.
- Ignored start: pulse start at accept+10 with different addr while busy -> the frame is unchanged and only one done occurs.
- Back-to-back: start held high -> the second accept happens on the done cycle, cs high for exactly 1 clk, and the second frame's timing is identical to the first.
- Parameter: HALF_PERIOD=1, read miso=8'hFF -> SCLK period 2 clk, done at accept+33, rdata=8'hFF.
